// File: rtl/geofence_xprod_arb_if.sv
// Requester/result bundle for the geofence cross-product arbiter.
// The master side drives requests; the slave side is the arbiter.
interface geofence_xprod_arb_if #(
  parameter int W = 11
);
  logic [1:0]         req;
  logic [4*W-1:0]     opnd0;
  logic [4*W-1:0]     opnd1;
  logic [1:0]         gnt;
  logic               res_valid;
  logic               res_id;
  logic signed [2*W:0] res;
  logic               res_neg;

  modport master (
    output req, opnd0, opnd1,
    input  gnt, res_valid, res_id, res, res_neg
  );

  modport slave (
    input  req, opnd0, opnd1,
    output gnt, res_valid, res_id, res, res_neg
  );
endinterface

// File: rtl/geofence_xprod_arb.sv
// Two-requester arbiter feeding one time-shared signed multiplier: ax*by - bx*ay.
// GEOFENCE_ARB_RR_EN selects round-robin arbitration; default is fixed priority.
module geofence_xprod_arb #(
  parameter int W = 11
) (
  input logic               clk,
  input logic               reset,
  geofence_xprod_arb_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_A,
    S_MUL_B,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_win;
  logic signed [W-1:0]   r_ax;
  logic signed [W-1:0]   r_ay;
  logic signed [W-1:0]   r_bx;
  logic signed [W-1:0]   r_by;
  logic signed [2*W-1:0] r_p1;
  logic signed [2*W:0]   r_res;
  logic                  r_id;
  logic                  r_neg;

  logic                  w_any;
  logic                  w_win;
  logic [4*W-1:0]        w_opnd;
  logic signed [W-1:0]   w_ma;
  logic signed [W-1:0]   w_mb;
  logic signed [2*W-1:0] w_prod;
  logic signed [2*W:0]   w_diff;
  logic [1:0]            w_gnt;

  assign w_any = |bus.req;

`ifdef GEOFENCE_ARB_RR_EN
  // r_ptr names the requester that wins a tie
  logic r_ptr;
  assign w_win = (bus.req == 2'b11) ? r_ptr : ~bus.req[0];
`else
  assign w_win = ~bus.req[0];
`endif

  assign w_opnd = w_win ? bus.opnd1 : bus.opnd0;

  assign w_ma   = (r_state == S_MUL_B) ? r_bx : r_ax;
  assign w_mb   = (r_state == S_MUL_B) ? r_ay : r_by;
  assign w_prod = w_ma * w_mb;
  assign w_diff = {r_p1[2*W-1], r_p1}
                - {w_prod[2*W-1], w_prod};

  always_comb begin
    w_next = r_state;
    w_gnt  = 2'b00;
    unique case (r_state)
      S_IDLE:  if (w_any) w_next = S_MUL_A;
      S_MUL_A: begin
        w_gnt[r_win] = 1'b1;
        w_next       = S_MUL_B;
      end
      S_MUL_B: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_win   <= 1'b0;
      r_ax    <= '0;
      r_ay    <= '0;
      r_bx    <= '0;
      r_by    <= '0;
      r_p1    <= '0;
      r_res   <= '0;
      r_id    <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_any) begin
        r_win <= w_win;
        r_ax  <= w_opnd[4*W-1:3*W];
        r_ay  <= w_opnd[3*W-1:2*W];
        r_bx  <= w_opnd[2*W-1:W];
        r_by  <= w_opnd[W-1:0];
      end
      if (r_state == S_MUL_A) r_p1 <= w_prod;
      if (r_state == S_MUL_B) begin
        r_res <= w_diff;
        r_id  <= r_win;
        r_neg <= w_diff[2*W];
      end
    end
  end

`ifdef GEOFENCE_ARB_RR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_ptr <= 1'b0;
    else if (r_state == S_IDLE && w_any)
      r_ptr <= ~w_win;
  end
`endif

  assign bus.gnt       = w_gnt;
  assign bus.res_valid = (r_state == S_DONE);
  assign bus.res_id    = r_id;
  assign bus.res       = r_res;
  assign bus.res_neg   = r_neg;

endmodule

// File: tb/tb_geofence_xprod_arb.sv
// Scoreboard bench for geofence_xprod_arb: directed vectors, monitor pops on res_valid.
// Expected arbitration order follows GEOFENCE_ARB_RR_EN.
module tb_geofence_xprod_arb;
  localparam int W = 11;

  typedef struct {
    logic signed [2*W:0] res;
    logic                id;
    logic                neg;
  } exp_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  exp_t q[$];

  geofence_xprod_arb_if #(.W(W)) bus ();

  geofence_xprod_arb #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [4*W-1:0] pk(input int ax, input int ay,
                                        input int bx, input int by);
    logic [W-1:0] a, b, c, d;
    a = ax[W-1:0];
    b = ay[W-1:0];
    c = bx[W-1:0];
    d = by[W-1:0];
    return {a, b, c, d};
  endfunction

  function automatic exp_t mk(input logic signed [2*W:0] r, input logic id);
    exp_t e;
    e.res = r;
    e.id  = id;
    e.neg = (r < 0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset && bus.res_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got res %0d expected no result",
                 $signed(bus.res));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("res",     $signed(bus.res), e.res);
        chk("res_id",  bus.res_id,       e.id);
        chk("res_neg", bus.res_neg,      e.neg);
      end
    end
  end

  // Issued at a negedge while the DUT is idle; returns at the next idle negedge.
  task automatic op(input logic [1:0] rq, input logic [4*W-1:0] o0,
                    input logic [4*W-1:0] o1, input logic [1:0] egnt,
                    input logic signed [2*W:0] eres,
                    input logic [1:0] rq_after, output int nwait);
    int n;
    bus.req   = rq;
    bus.opnd0 = o0;
    bus.opnd1 = o1;
    q.push_back(mk(eres, egnt[1]));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.gnt == 2'b00 && n < 20);
    chk("gnt", bus.gnt, egnt);
    bus.req = rq_after;
    @(negedge clk);
    chk("gnt_pulse", bus.gnt, 0);
    chk("rv_mul_b", bus.res_valid, 0);
    @(negedge clk);
    chk("rv_done", bus.res_valid, 1);
    @(negedge clk);
    chk("rv_idle", bus.res_valid, 0);
    chk("res_hold", $signed(bus.res), eres);
    nwait = n;
  endtask

  logic [4*W-1:0] vA, vB;
  logic [1:0]     g;
  logic signed [2*W:0] r;
  int nw;

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    bus.req   = 2'b00;
    bus.opnd0 = '0;
    bus.opnd1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_rv",  bus.res_valid, 0);
    chk("rst_res", $signed(bus.res), 0);
    chk("rst_id",  bus.res_id, 0);
    chk("rst_neg", bus.res_neg, 0);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_gnt", bus.gnt, 0);
      chk("idle_rv", bus.res_valid, 0);
    end

    // basic, extremes, collinear
    op(2'b01, pk(3, 4, 5, -2), '0, 2'b01, -26, 2'b00, nw);
    chk("latency", nw, 1);
    op(2'b01, pk(1023, -1023, -1023, -1023), '0, 2'b01, -2093058, 2'b00, nw);
    op(2'b10, '0, pk(2, 4, 1, 2), 2'b10, 0, 2'b00, nw);
    chk("zero_neg", bus.res_neg, 0);

    // req[1] raised during MUL_A of a req[0] op
    bus.req   = 2'b01;
    bus.opnd0 = pk(2, 3, 4, 5);
    q.push_back(mk(-2, 1'b0));
    nw = 0;
    do begin
      @(negedge clk);
      nw++;
    end while (bus.gnt == 2'b00 && nw < 20);
    chk("gnt0", bus.gnt, 2'b01);
    bus.req   = 2'b10;
    bus.opnd1 = pk(-5, 6, 7, 8);
    q.push_back(mk(-82, 1'b1));
    @(negedge clk);
    chk("late_mul_b", bus.gnt, 0);
    @(negedge clk);
    chk("late_done", bus.gnt, 0);
    @(negedge clk);
    chk("late_idle", bus.gnt, 0);
    @(negedge clk);
    chk("late_gnt1", bus.gnt, 2'b10);
    bus.req = 2'b00;
    @(negedge clk);
    chk("late_gnt1_pulse", bus.gnt, 0);
    repeat (2) @(negedge clk);

    // fresh pointer, both requesters held
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vA = pk(3, 4, 5, -2);
    vB = pk(1, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
`ifdef GEOFENCE_ARB_RR_EN
      g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      g = 2'b01;
`endif
      r = g[1] ? 1 : -26;
      op(2'b11, vA, vB, g, r, (i == 3) ? 2'b00 : 2'b11, nw);
      chk("period", nw, 1);
    end

    // reset during MUL_B
    bus.req   = 2'b01;
    bus.opnd0 = pk(1023, -1023, -1023, -1023);
    bus.opnd1 = '0;
    nw = 0;
    do begin
      @(negedge clk);
      nw++;
    end while (bus.gnt == 2'b00 && nw < 20);
    chk("abort_gnt", bus.gnt, 2'b01);
    bus.req = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_res", $signed(bus.res), 0);
    chk("abort_id",  bus.res_id, 0);
    chk("abort_neg", bus.res_neg, 0);
    chk("abort_gnt0", bus.gnt, 0);
    chk("abort_rv", bus.res_valid, 0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_rv_hold", bus.res_valid, 0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_rv", bus.res_valid, 0);
    op(2'b10, '0, pk(1, 0, 0, 1), 2'b10, 1, 2'b00, nw);
    chk("post_rst_id", bus.res_id, 1);

    repeat (6) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/geofence_xprod_arb.md
GEOFENCE_XPROD_ARB -- requirements
Module: geofence_xprod_arb

Interface
REQ-001 SHALL have parameter W, default 11, the signed operand width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req  input  2  per-requester request; req[i] high means opnd_i is valid.
REQ-005 SHALL have port opnd0  input  4*W  requester 0 vectors, packed {ax, ay, bx, by}, each signed W.
REQ-006 SHALL have port opnd1  input  4*W  requester 1 vectors, same packing as opnd0.
REQ-007 SHALL have port gnt  output  2  one-hot grant pulse, one cycle, marking capture of the winner's operands.
REQ-008 SHALL have port res_valid  output  1  one-cycle pulse; res, res_id and res_neg are valid.
REQ-009 SHALL have port res_id  output  1  index of the requester that owns res.
REQ-010 SHALL have port res  output  2*W+1  signed cross product ax*by - bx*ay.
REQ-011 SHALL have port res_neg  output  1  high when res < 0.

Function
REQ-012 SHALL implement the FSM IDLE -> MUL_A -> MUL_B -> DONE -> IDLE.
REQ-013 IDLE with any req high SHALL capture the winner's operands at the edge and go to MUL_A; with no req it SHALL stay in IDLE.
REQ-014 In MUL_A, gnt[winner] SHALL be 1; gnt SHALL be 0 in all other states.
REQ-015 req SHALL be ignored in MUL_A, MUL_B and DONE; a pending request is served at the next IDLE.
REQ-016 A requester SHALL hold req and its operands until it sees its gnt bit high; a request withdrawn before grant SHALL have no effect.
REQ-017 One signed W x W multiplier SHALL be used, time-shared:
- MUL_A registers p1 = ax*by (2W bits).
- MUL_B registers res = p1 - bx*ay (2W+1 bits, sign-extended, never overflows).
REQ-018 res_valid SHALL be 1 exactly during DONE; res_id and res_neg SHALL be updated with res.
REQ-019 res, res_id and res_neg SHALL hold their values until the next DONE.
REQ-020 Latency SHALL be 3 cycles: capture edge E0, res_valid high in the cycle after E2. Minimum issue period SHALL be 4 cycles.
REQ-021 A zero result SHALL give res_neg = 0.

Reset
REQ-022 reset low SHALL immediately force:
- state = IDLE;
- gnt = 0, res_valid = 0, res_id = 0, res = 0, res_neg = 0;
- p1 = 0, captured operands = 0;
- round-robin pointer favouring requester 0.
REQ-023 reset asserted mid-operation SHALL abort the operation with no res_valid pulse; operation resumes from IDLE after reset deasserts.

Configuration
REQ-024 With macro GEOFENCE_ARB_RR_EN defined, arbitration SHALL be round-robin:
- if both requesters are high, the one not granted last wins;
- the pointer updates only on a grant.
REQ-025 Without GEOFENCE_ARB_RR_EN, arbitration SHALL be fixed priority (req[0] always wins) and no pointer register is built.

Verification
REQ-026 req=01, opnd0 A=(3,4) B=(5,-2) -> gnt=01 one cycle; 3 cycles after capture res_valid=1, res=-26, res_id=0, res_neg=1.
REQ-027 req=11 held continuously, 4 ops -> with RR_EN res_id sequence 0,1,0,1; without it 0,0,0,0; one res_valid every 4 cycles.
REQ-028 Extremes A=(1023,-1023) B=(-1023,-1023) -> res=-2093058, res_neg=1, no overflow.
REQ-029 Collinear A=(2,4) B=(1,2) -> res=0, res_neg=0.
REQ-030 reset low during MUL_B -> no res_valid; all outputs 0 at once; after release, req=10 with A=(1,0) B=(0,1) -> res=1, res_id=1.
REQ-031 req[1] raised during MUL_A of a req[0] op -> gnt[1] not before the next IDLE; gnt[1] high exactly one cycle.
